// File: rtl/csa_resolver.sv
// -----------------------------------------------------------------------------
// csa_resolver
//   Carry-save to binary resolver at the tail of the Booth-4 / Wallace 16x16
//   multiplier. Takes the final redundant pair (sum vector, carry vector) from
//   the last compressor row and returns {out_cout, out_data} = in_sum + in_carry
//   under a valid/ready handshake. Results come out in acceptance order.
//
//   Configuration macro: RESOLVER_PIPE2_EN
//     defined   : split adder. S1 adds the low halves and registers the
//                 mid carry. S2 adds the high halves plus that carry.
//                 Latency 2, capacity 2.
//     undefined : one full-width add registered straight into the output
//                 stage. Latency 1, capacity 1.
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in_valid   in   in_sum/in_carry valid
//   in_ready   out  block can accept this cycle
//   in_sum     in   [WIDTH-1:0] sum vector, bit-weighted
//   in_carry   in   [WIDTH-1:0] carry vector, already shifted to its weight
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts
//   out_data   out  [WIDTH-1:0] (in_sum + in_carry) mod 2^WIDTH
//   out_cout   out  carry out of bit WIDTH-1 (checking only)
// -----------------------------------------------------------------------------
module csa_resolver #(
    parameter int WIDTH = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

`ifdef RESOLVER_PIPE2_EN

    localparam int HALF = WIDTH / 2;

    // S1 state: low-half result, mid carry, untouched high halves.
    logic            s1_valid;
    logic [HALF-1:0] s1_lo_sum;
    logic            s1_c_mid;
    logic [HALF-1:0] s1_hi_s;
    logic [HALF-1:0] s1_hi_c;

    logic            s2_advance;
    logic            s1_advance;
    logic            s1_load;
    logic            s2_load;
    logic [HALF:0]   lo_add;
    logic [HALF:0]   hi_add;

    // A stage may take new data when it is empty or its content leaves this
    // cycle; this lets a full pipe move every cycle with no bubble.
    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;

    assign s1_load = in_valid && in_ready;
    assign s2_load = s1_valid && s2_advance;

    assign lo_add = {1'b0, in_sum[HALF-1:0]} + {1'b0, in_carry[HALF-1:0]};
    assign hi_add = {1'b0, s1_hi_s} + {1'b0, s1_hi_c} + {{HALF{1'b0}}, s1_c_mid};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the data registers are only qualified by the valid bits and
            // would work unreset; they are cleared anyway so outputs are
            // deterministic straight out of reset.
            s1_valid  <= 1'b0;
            s1_lo_sum <= '0;
            s1_c_mid  <= 1'b0;
            s1_hi_s   <= '0;
            s1_hi_c   <= '0;
        end else if (s1_load) begin
            s1_valid  <= 1'b1;
            s1_lo_sum <= lo_add[HALF-1:0];
            s1_c_mid  <= lo_add[HALF];
            s1_hi_s   <= in_sum[WIDTH-1:HALF];
            s1_hi_c   <= in_carry[WIDTH-1:HALF];
        end else if (s1_advance) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cout  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_data  <= {hi_add[HALF-1:0], s1_lo_sum};
            out_cout  <= hi_add[HALF];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`else

    logic           load;
    logic [WIDTH:0] full_add;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;
    assign full_add = {1'b0, in_sum} + {1'b0, in_carry};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: out_data/out_cout are qualified by out_valid and would work
            // unreset; they are cleared anyway for deterministic outputs.
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cout  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= full_add[WIDTH-1:0];
            out_cout  <= full_add[WIDTH];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

endmodule
